// File: rtl/echo_decodificador_pkg.sv
// rtl/echo_decodificador_pkg.sv - shared constants and FSM encoding for the echo decoder
package echo_decodificador_pkg;

    localparam int                CODE_W            = 5;
    localparam logic [CODE_W-1:0] BLANK_CODE        = 5'b00000;
    localparam int                STABLE_CYCLES_DEF = 4;
    // Settle counter must reach STABLE_CYCLES up to 15.
    localparam int                SCNT_W            = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/echo_decodificador_classifica.sv
// rtl/echo_decodificador_classifica.sv - combinational code word classifier
module echo_classifica
    import echo_decodificador_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic              o_valid,
    output logic              o_blank,
    output logic              o_invalid,
    output logic              o_re,
    output logic              o_rs,
    output logic              o_a,
    output logic              o_b,
    output logic              o_c,
    output logic              o_d
);

    // S1 set marks a data word; all-zero is blank; anything else is a bad code.
    always_comb begin
        o_valid   = 1'b0;
        o_blank   = 1'b0;
        o_invalid = 1'b0;
        o_re      = 1'b0;
        o_rs      = 1'b0;
        o_a       = 1'b0;
        o_b       = 1'b0;
        o_c       = 1'b0;
        o_d       = 1'b0;
        if (i_code[CODE_W-1]) begin
            o_valid = 1'b1;
            o_re    = 1'b1;
            o_a     = i_code[3];
            o_b     = i_code[2];
            o_c     = i_code[1];
            o_d     = i_code[0];
        end else if (i_code == BLANK_CODE) begin
            o_blank = 1'b1;
        end else begin
            o_invalid = 1'b1;
        end
    end

endmodule

// File: rtl/echo_decodificador.sv
// rtl/echo_decodificador.sv - debounced 5-bit code word decoder with valid/ready output
module echo_decodificador
    import echo_decodificador_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S1,
    input  logic             S2,
    input  logic             S3,
    input  logic             S4,
    input  logic             S5,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic             RE,
    output logic             RS,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             out_valid,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
);

    state_t             r_state, w_state_nxt;
    logic [CODE_W-1:0]  r_samp;
    logic [CODE_W-1:0]  r_ref, w_ref_nxt;
    logic [CODE_W-1:0]  r_last_word, w_last_nxt;
    logic [SCNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [5:0]         r_dec, w_dec_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_err, w_err_nxt, w_err_set;
    logic [CNT_W-1:0]   r_word_cnt, w_word_cnt_nxt;

    logic w_valid, w_blank, w_invalid;
    logic w_re, w_rs, w_a, w_b, w_c, w_d;

    echo_classifica u_classifica (
        .i_code    (r_ref),
        .o_valid   (w_valid),
        .o_blank   (w_blank),
        .o_invalid (w_invalid),
        .o_re      (w_re),
        .o_rs      (w_rs),
        .o_a       (w_a),
        .o_b       (w_b),
        .o_c       (w_c),
        .o_d       (w_d)
    );

    // Resynchronise the asynchronous code lines; everything downstream uses r_samp only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp <= BLANK_CODE;
        end else begin
            r_samp <= {S1, S2, S3, S4, S5};
        end
    end

    // Next-state and datapath decisions for the IDLE/SETTLE/HOLD debounce FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_ref_nxt      = r_ref;
        w_last_nxt     = r_last_word;
        w_cnt_nxt      = r_cnt;
        w_dec_nxt      = r_dec;
        w_valid_nxt    = r_valid;
        w_word_cnt_nxt = r_word_cnt;
        w_err_set      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_samp != r_last_word) begin
                    w_state_nxt = ST_SETTLE;
                    w_ref_nxt   = r_samp;
                    w_cnt_nxt   = SCNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (r_samp != r_ref) begin
                    // Any glitch restarts the stability window on the new value.
                    w_ref_nxt = r_samp;
                    w_cnt_nxt = SCNT_W'(1);
                end else if (r_cnt < SCNT_W'(STABLE_CYCLES)) begin
                    w_cnt_nxt = r_cnt + SCNT_W'(1);
                end else begin
                    w_last_nxt  = r_ref;
                    w_state_nxt = ST_IDLE;
                    if (w_valid) begin
                        w_dec_nxt   = {w_re, w_rs, w_a, w_b, w_c, w_d};
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else if (w_invalid) begin
                        w_err_set = 1'b1;
                    end else if (w_blank) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (r_valid && out_ready) begin
                    w_valid_nxt    = 1'b0;
                    w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A new error wins over a simultaneous clear so it is never missed.
        w_err_nxt = w_err_set ? 1'b1 : (err_clr ? 1'b0 : r_err);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ref       <= BLANK_CODE;
            r_last_word <= BLANK_CODE;
            r_cnt       <= '0;
            r_dec       <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ref       <= w_ref_nxt;
            r_last_word <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dec       <= w_dec_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
        end
    end

    assign {RE, RS, A, B, C, D} = r_dec;
    assign out_valid            = r_valid;
    assign err                  = r_err;
    assign word_cnt             = r_word_cnt;

endmodule

// File: tb/tb_echo_decodificador.sv
// tb/tb_echo_decodificador.sv - self-checking bench for echo_decodificador
module tb_echo_decodificador;

    localparam int STABLE = 4;
    localparam int CW     = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    s_in = 5'b00000;
    logic          out_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic          RE, RS, A, B, C, D, out_valid, err;
    logic [CW-1:0] word_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    echo_decodificador #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .S1        (s_in[4]),
        .S2        (s_in[3]),
        .S3        (s_in[2]),
        .S4        (s_in[1]),
        .S5        (s_in[0]),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .RE        (RE),
        .RS        (RS),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .out_valid (out_valid),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a candidate word is accepted once it has been observed on
    // STABLE+1 consecutive samples after first differing from the last accepted word.
    logic          m_hold, m_valid, m_err, m_win, m_re;
    logic [4:0]    m_samp, m_cand, m_last;
    logic [3:0]    m_abcd;
    int            m_age;
    logic [CW-1:0] m_cnt;

    always @(posedge clk or posedge rst) begin : model
        logic h, v, w, se, re;
        logic [4:0] c, l;
        logic [3:0] ab;
        int ag;
        logic [CW-1:0] n;
        if (rst) begin
            m_hold <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0; m_win <= 1'b0; m_re <= 1'b0;
            m_samp <= 5'd0; m_cand <= 5'd0; m_last <= 5'd0; m_abcd <= 4'd0; m_age <= 0;
            m_cnt  <= '0;
        end else begin
            h = m_hold; v = m_valid; w = m_win; c = m_cand; l = m_last;
            ab = m_abcd; re = m_re; ag = m_age; n = m_cnt; se = 1'b0;
            if (h) begin
                if (out_ready) begin
                    h = 1'b0; v = 1'b0; n = n + 1'b1;
                end
            end else if (!w) begin
                if (m_samp != l) begin
                    w = 1'b1; c = m_samp; ag = 0;
                end
            end else if (m_samp != c) begin
                c = m_samp; ag = 0;
            end else begin
                ag = ag + 1;
                if (ag == STABLE) begin
                    w = 1'b0;
                    l = c;
                    if (c[4]) begin
                        h = 1'b1; v = 1'b1; ab = c[3:0]; re = 1'b1;
                    end else if (c != 5'd0) begin
                        se = 1'b1;
                    end
                end
            end
            m_hold <= h; m_valid <= v; m_win <= w; m_cand <= c; m_last <= l;
            m_abcd <= ab; m_re <= re; m_age <= ag; m_cnt <= n;
            m_err  <= se ? 1'b1 : (err_clr ? 1'b0 : m_err);
            m_samp <= s_in;
        end
    end

    // Cycle-by-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            check("cyc_valid", 32'(out_valid), 32'(m_valid));
            check("cyc_data", 32'({RE, RS, A, B, C, D}), 32'({m_re, 1'b0, m_abcd}));
            check("cyc_err", 32'(err), 32'(m_err));
            check("cyc_cnt", 32'(word_cnt), 32'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_watch(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({"valid_seen_", tag}, 32'(out_valid), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({"rst_outs_", tag}, 32'({RE, RS, A, B, C, D, out_valid, err}), 32'd0);
        check({"rst_cnt_", tag}, 32'(word_cnt), 32'd0);
    endtask

    logic seen;
    logic [4:0] words [5];
    logic [CW-1:0] exp_cnt [5];
    logic [4:0] w_prev;

    initial begin
        words   = '{5'b10001, 5'b10010, 5'b10100, 5'b11000, 5'b11111};
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        #2 rst = 1'b1;
        #1 check_all_zero("init");
        @(negedge clk) rst = 1'b0;
        check_en = 1'b1;

        // Single valid word, ready high: valid after the 6th edge, then handshake.
        s_in = 5'b11010; out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("lat_early", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'({RE, RS, A, B, C, D}), 32'(6'b10_1010));
        @(negedge clk);
        check("lat_release", 32'(out_valid), 32'd0);
        check("lat_cnt", 32'(word_cnt), 32'd1);

        // Chatter between two words every 3 cycles never settles.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_in = ((i / 3) % 2 == 1) ? 5'b10011 : 5'b10001;
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("chatter_no_valid", 32'(seen), 32'd0);
        s_in = 5'b10011;
        wait_valid("chatter", 12);
        check("chatter_data", 32'({A, B, C, D}), 32'(4'b0011));
        tick_watch(10, seen);
        check("chatter_single", 32'(seen), 32'd0);
        check("chatter_cnt", 32'(word_cnt), 32'd2);

        // Invalid code sets err; clear works; set wins over simultaneous clear.
        s_in = 5'b00110;
        tick_watch(8, seen);
        check("inv_err", 32'(err), 32'd1);
        check("inv_no_valid", 32'(seen), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("inv_cleared", 32'(err), 32'd0);
        s_in = 5'b01001;
        tick(5);
        check("inv_before_set", 32'(err), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("inv_set_wins", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // Output frozen in HOLD; later change is picked up after the handshake.
        out_ready = 1'b0;
        s_in = 5'b10111;
        wait_valid("hold1", 10);
        check("hold_data", 32'({A, B, C, D}), 32'(4'b0111));
        s_in = 5'b11111;
        tick(8);
        check("hold_frozen_v", 32'(out_valid), 32'd1);
        check("hold_frozen_d", 32'({A, B, C, D}), 32'(4'b0111));
        out_ready = 1'b1;
        tick(1);
        check("hold_release", 32'(out_valid), 32'd0);
        check("hold_cnt", 32'(word_cnt), 32'd3);
        wait_valid("hold2", 10);
        check("hold_second", 32'({A, B, C, D}), 32'(4'b1111));
        tick(1);
        check("hold_wrap", 32'(word_cnt), 32'd0);

        // Counter wrap sequence with blanks in between.
        s_in = 5'b00000;
        #1 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_in = words[i];
            wait_valid("wrap", 10);
            tick(1);
            check("wrap_cnt", 32'(word_cnt), 32'(exp_cnt[i]));
            s_in = 5'b00000;
            tick_watch(8, seen);
            check("blank_cnt", 32'(word_cnt), 32'(exp_cnt[i]));
            check("blank_no_valid", 32'(seen), 32'd0);
        end

        // Reset during SETTLE.
        s_in = 5'b10101;
        tick(3);
        #1 rst = 1'b1;
        #1 check_all_zero("settle");
        s_in = 5'b00000;
        @(negedge clk) rst = 1'b0;
        tick_watch(10, seen);
        check("settle_no_valid", 32'(seen), 32'd0);
        check("settle_no_cnt", 32'(word_cnt), 32'd0);

        // Reset during HOLD.
        out_ready = 1'b0;
        s_in = 5'b10101;
        wait_valid("rsthold", 10);
        #1 rst = 1'b1;
        #1 check_all_zero("hold");
        s_in = 5'b00000;
        out_ready = 1'b1;
        @(negedge clk) rst = 1'b0;
        tick_watch(10, seen);
        check("hold_rst_no_valid", 32'(seen), 32'd0);
        check("hold_rst_no_cnt", 32'(word_cnt), 32'd0);

        // Randomised traffic against the reference.
        w_prev = 5'b00000;
        for (int seg = 0; seg < 400; seg++) begin
            case ($urandom_range(0, 5))
                0:       s_in = 5'b00000;
                1:       s_in = 5'(($urandom_range(1, 15)));
                2:       s_in = w_prev;
                default: s_in = {1'b1, 4'($urandom_range(0, 15))};
            endcase
            w_prev = s_in;
            for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
                out_ready = ($urandom_range(0, 9) < 7);
                err_clr   = ($urandom_range(0, 9) == 0);
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        err_clr   = 1'b0;
        tick(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
